// File: rtl/video_pkg.sv
// video_pkg: shared region codes, drain FSM states and FIFO entry layout for the video write scheduler
package video_pkg;

    localparam logic [3:0] REG_CFG     = 4'd0;
    localparam logic [3:0] REG_TEX     = 4'd1;
    localparam logic [3:0] REG_TILE    = 4'd2;
    localparam logic [3:0] REG_SPR     = 4'd3;
    localparam logic [3:0] IRQ_ACK_IDX = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } drain_state_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_entry_t;

    function automatic logic is_mem_region(input logic [3:0] region);
        return region == REG_TEX || region == REG_TILE || region == REG_SPR;
    endfunction

endpackage

// File: rtl/video_wr_scheduler_if.sv
// video_wr_scheduler_if: CPU iomem bus (valid/ready handshake, strobes, address, write data)
//   master: CPU side, drives the request; slave: scheduler side, drives iomem_ready
interface video_wr_scheduler_if;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready
    );

endinterface

// File: rtl/video_wr_fifo.sv
// video_wr_fifo: synchronous FIFO holding queued video memory writes
//   clk/resetn  clock, async active-low reset (flushes pointers)
//   push/wdata  enqueue; ignored when full unless a pop happens in the same cycle
//   pop/rdata   dequeue; rdata shows the head entry combinationally
//   full/empty  status from the extra pointer MSB
module video_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, do_push};
            rp <= rp + {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/video_wr_scheduler.sv
// video_wr_scheduler: queues CPU writes to video memories and drains them only during blanking
//   clk, resetn           clock, async active-low reset
//   bus (slave)           iomem valid/ready/wstrb/addr/wdata from the CPU
//   video_active          high during the visible area; blocks memory writes
//   vga_vsync             vsync; its active edge raises vblank_irq and counts a frame
//   mem_wen/sel/waddr/wdata  registered write port into texture/tile/sprite memory
//   vblank_irq            sticky interrupt, cleared by a write to region 0 word 0xF
//   frame_cnt             frames since reset, wrapping
module video_wr_scheduler
    import video_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    video_wr_scheduler_if.slave   bus,
    input  logic                  video_active,
    input  logic                  vga_vsync,
    output logic                  mem_wen,
    output logic [1:0]            mem_sel,
    output logic [13:0]           mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  vblank_irq,
    output logic [15:0]           frame_cnt
);

    logic [3:0]   region;
    logic         wr_req, claim, ack, push, pop, full, empty, vs_q, vs_edge;
    drain_state_t state;
    wr_entry_t    in_e, out_e;
    logic         unused_addr_bits;

    assign region  = bus.iomem_addr[23:20];
    assign wr_req  = bus.iomem_valid && |bus.iomem_wstrb;
    assign claim   = wr_req && is_mem_region(region);
    // iomem_ready is high in the cycle after an accept, which blocks a second accept while valid falls
    assign ack     = wr_req && region == REG_CFG && bus.iomem_addr[5:2] == IRQ_ACK_IDX && !bus.iomem_ready;
    // state follows the current inputs so a rising video_active stops pops in that same cycle
    assign state   = video_active ? S_ACTIVE : empty ? S_IDLE : S_DRAIN;
    assign pop     = state == S_DRAIN;
    assign push    = claim && !bus.iomem_ready && (!full || pop);
    assign vs_edge = (vga_vsync == VSYNC_POL) && (vs_q != VSYNC_POL);
    assign in_e    = '{sel: region[1:0], addr: bus.iomem_addr[15:2], data: bus.iomem_wdata};
    assign unused_addr_bits = ^{bus.iomem_addr[31:24], bus.iomem_addr[19:16], bus.iomem_addr[1:0]};

    video_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (in_e),
        .rdata  (out_e),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.iomem_ready <= 1'b0;
            mem_wen         <= 1'b0;
            mem_sel         <= '0;
            mem_waddr       <= '0;
            mem_wdata       <= '0;
            vblank_irq      <= 1'b0;
            frame_cnt       <= '0;
            // starting at the active level means a vsync already active at release is not an edge
            vs_q            <= VSYNC_POL;
        end else begin
            bus.iomem_ready <= push || ack;
            mem_wen         <= pop;
            if (pop) begin
                mem_sel   <= out_e.sel;
                mem_waddr <= out_e.addr;
                mem_wdata <= out_e.data;
            end
            vs_q       <= vga_vsync;
            vblank_irq <= vs_edge || (vblank_irq && !ack);
            frame_cnt  <= frame_cnt + {15'd0, vs_edge};
        end
    end

endmodule

// File: tb/tb_video_wr_scheduler.sv
// tb_video_wr_scheduler: directed scoreboard bench for video_wr_scheduler
module tb_video_wr_scheduler;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        video_active = 1'b0;
    logic        vga_vsync = 1'b1;
    logic        mem_wen, vblank_irq;
    logic [1:0]  mem_sel;
    logic [13:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] frame_cnt;
    int          errors = 0;
    int          checks = 0;
    int          wen_cnt = 0;
    int          w0;
    bit          got;
    logic [47:0] sb [$];
    logic [47:0] exp_e;

    video_wr_scheduler_if bus ();

    video_wr_scheduler #(
        .DEPTH     (4),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .video_active (video_active),
        .vga_vsync    (vga_vsync),
        .mem_wen      (mem_wen),
        .mem_sel      (mem_sel),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .vblank_irq   (vblank_irq),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            wen_cnt++;
            if (sb.size() == 0) chk("unexpected_wen", 64'(1), 64'(0));
            else begin
                exp_e = sb.pop_front();
                chk("mem_write", 64'({mem_sel, mem_waddr, mem_wdata}), 64'(exp_e));
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wdata = d;
        bus.iomem_wstrb = s;
        if (s != 4'h0 && a[23:20] inside {4'd1, 4'd2, 4'd3}) sb.push_back({a[21:20], a[15:2], d});
    endtask

    task automatic idle_bus();
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.iomem_ready;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        bit seen;
        drive(a, d, 4'hF);
        wait_ready(4, seen);
        idle_bus();
        chk(tag, 64'(seen), 64'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(bus.iomem_ready), 64'(0));
        chk({tag, "_wen"}, 64'(mem_wen), 64'(0));
        chk({tag, "_sel"}, 64'(mem_sel), 64'(0));
        chk({tag, "_waddr"}, 64'(mem_waddr), 64'(0));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_irq"}, 64'(vblank_irq), 64'(0));
        chk({tag, "_frame"}, 64'(frame_cnt), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_bus();
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        #12;
        chk_zero("reset");
        resetn = 1'b1;
        cycles(2);

        // single write in blanking: ready at N+1, memory write at N+2
        w0 = wen_cnt;
        wr(32'h0520_0010, 32'h2A, "t1_ready");
        cycles(1);
        chk("t1_ready_pulse", 64'(bus.iomem_ready), 64'(0));
        chk("t1_wen", 64'(mem_wen), 64'(1));
        chk("t1_sel", 64'(mem_sel), 64'(2));
        chk("t1_waddr", 64'(mem_waddr), 64'(4));
        chk("t1_wdata", 64'(mem_wdata), 64'(32'h2A));
        cycles(3);
        chk("t1_count", 64'(wen_cnt - w0), 64'(1));

        // fill the FIFO during active video; fifth write stalls until blanking
        video_active = 1'b1;
        w0 = wen_cnt;
        for (int i = 0; i < 4; i++)
            wr(32'h0500_0000 | (32'(i % 3 + 1) << 20) | 32'(i * 4), 32'h100 + 32'(i), "t2_accept");
        cycles(2);
        chk("t2_no_wen_active", 64'(wen_cnt - w0), 64'(0));
        drive(32'h0530_0040, 32'h105, 4'hF);
        wait_ready(6, got);
        chk("t2_stall", 64'(got), 64'(0));
        video_active = 1'b0;
        wait_ready(6, got);
        idle_bus();
        chk("t2_fifth_accept", 64'(got), 64'(1));
        cycles(8);
        chk("t2_count", 64'(wen_cnt - w0), 64'(5));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));

        // active video returns after two pops; the rest drain at the next blanking
        video_active = 1'b1;
        for (int i = 0; i < 4; i++)
            wr(32'h0520_0000 | (32'(i % 2) << 20) | 32'(i * 8 + 4), 32'hA0 + 32'(i), "t3_accept");
        cycles(1);
        w0 = wen_cnt;
        video_active = 1'b0;
        cycles(2);
        video_active = 1'b1;
        cycles(5);
        chk("t3_partial", 64'(wen_cnt - w0), 64'(2));
        chk("t3_sb_left", 64'(sb.size()), 64'(2));
        video_active = 1'b0;
        cycles(6);
        chk("t3_rest", 64'(wen_cnt - w0), 64'(4));
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));

        // vsync edges count frames and raise the irq; ack clears it unless an edge coincides
        repeat (3) begin
            vga_vsync = 1'b0;
            cycles(1);
            vga_vsync = 1'b1;
            cycles(3);
        end
        chk("t4_frame3", 64'(frame_cnt), 64'(3));
        chk("t4_irq_set", 64'(vblank_irq), 64'(1));
        wr(32'h0500_003C, 32'h0, "t4_ack_ready");
        chk("t4_irq_cleared", 64'(vblank_irq), 64'(0));
        chk("t4_frame_hold", 64'(frame_cnt), 64'(3));
        cycles(1);
        drive(32'h0500_003C, 32'h0, 4'hF);
        vga_vsync = 1'b0;
        cycles(1);
        idle_bus();
        vga_vsync = 1'b1;
        chk("t4_ack_edge_ready", 64'(bus.iomem_ready), 64'(1));
        chk("t4_set_wins", 64'(vblank_irq), 64'(1));
        chk("t4_frame4", 64'(frame_cnt), 64'(4));
        cycles(2);
        chk("t4_irq_sticky", 64'(vblank_irq), 64'(1));

        // other region-0 writes and reads are ignored
        w0 = wen_cnt;
        drive(32'h0500_0008, 32'h55, 4'hF);
        wait_ready(5, got);
        idle_bus();
        chk("t5_cfg_no_ready", 64'(got), 64'(0));
        drive(32'h0510_0000, 32'h66, 4'h0);
        wait_ready(5, got);
        idle_bus();
        chk("t5_read_no_ready", 64'(got), 64'(0));
        cycles(3);
        chk("t5_no_wen", 64'(wen_cnt - w0), 64'(0));
        chk("t5_irq_kept", 64'(vblank_irq), 64'(1));

        // reset with queued writes flushes them
        video_active = 1'b1;
        for (int i = 0; i < 3; i++)
            wr(32'h0530_0100 + 32'(i * 4), 32'hC0 + 32'(i), "t6_accept");
        cycles(1);
        #2 resetn = 1'b0;
        #1 chk_zero("t6_reset");
        sb.delete();
        w0 = wen_cnt;
        #3 resetn = 1'b1;
        video_active = 1'b0;
        cycles(10);
        chk("t6_flushed", 64'(wen_cnt - w0), 64'(0));
        wr(32'h0510_0020, 32'h77, "t6_post_accept");
        cycles(3);
        chk("t6_post_wen", 64'(wen_cnt - w0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
